// File: rtl/register_file_if.sv
// register_file_if: bundles the writeback, read-port, load-issue and status
// signals of the integer register file. The pipeline side uses the master
// modport and the register file itself uses the slave modport.
interface register_file_if;
    logic        rd_enable_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;

    logic        re1_i;
    logic [4:0]  raddr1_i;
    logic [31:0] rdata1_o;

    logic        re2_i;
    logic [4:0]  raddr2_i;
    logic [31:0] rdata2_o;

    logic        issue_load_i;
    logic [4:0]  issue_rd_i;

    logic        stall_req_o;
    logic        err_o;

    modport master (
        output rd_enable_i, rd_addr_i, rd_data_i,
        output re1_i, raddr1_i, re2_i, raddr2_i,
        output issue_load_i, issue_rd_i,
        input  rdata1_o, rdata2_o, stall_req_o, err_o
    );

    modport slave (
        input  rd_enable_i, rd_addr_i, rd_data_i,
        input  re1_i, raddr1_i, re2_i, raddr2_i,
        input  issue_load_i, issue_rd_i,
        output rdata1_o, rdata2_o, stall_req_o, err_o
    );
endinterface

// File: rtl/register_file.sv
// register_file: 32x32 architectural integer registers with two combinational
// read ports, MEM/WB writeback, and a per-register load scoreboard that asks
// the ID stage to stall while an operand is still in flight.
// Optional feature macro: REGFILE_BYPASS_EN forwards the writeback value to
// the read ports in the same cycle and releases the stall one cycle earlier.
// x0 is hard-wired to zero and has neither storage nor a scoreboard counter.
module register_file (
    input  logic           clk,
    input  logic           rst,
    register_file_if.slave bus
);

    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];
    logic [1:0]  cnt_q  [1:31];
    logic [1:0]  cnt_d  [1:31];
    logic        err_q;
    logic        err_d;

    logic [31:0] arr1;
    logic [31:0] arr2;
    logic [1:0]  cnt1;
    logic [1:0]  cnt2;
    logic        fwd1;
    logic        fwd2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        busy1;
    logic        busy2;

    // Next array contents: a valid writeback to a nonzero register replaces it.
    always_comb begin
        regs_d = regs_q;
        for (int r = 1; r < 32; r++) begin
            if (bus.rd_enable_i && (bus.rd_addr_i == 5'(r))) begin
                regs_d[r] = bus.rd_data_i;
            end
        end
    end

    // Next scoreboard counts: loads issued raise the count, their writebacks lower it.
    always_comb begin
        logic inc;
        logic dec;
        inc   = 1'b0;
        dec   = 1'b0;
        cnt_d = cnt_q;
        err_d = err_q;
        for (int r = 1; r < 32; r++) begin
            inc = bus.issue_load_i && (bus.issue_rd_i == 5'(r));
            dec = bus.rd_enable_i && (bus.rd_addr_i == 5'(r)) && (cnt_q[r] != 2'd0);
            if (inc && !dec) begin
                if (cnt_q[r] == 2'd3) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + 2'd1;
                end
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - 2'd1;
            end
        end
    end

    // Array and scoreboard lookup for both read addresses; x0 yields zero.
    always_comb begin
        arr1 = '0;
        arr2 = '0;
        cnt1 = '0;
        cnt2 = '0;
        for (int r = 1; r < 32; r++) begin
            if (bus.raddr1_i == 5'(r)) begin
                arr1 = regs_q[r];
                cnt1 = cnt_q[r];
            end
            if (bus.raddr2_i == 5'(r)) begin
                arr2 = regs_q[r];
                cnt2 = cnt_q[r];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Detect a writeback landing this cycle on the register each port reads.
    always_comb begin
        fwd1 = bus.rd_enable_i && (bus.rd_addr_i == bus.raddr1_i) && (bus.raddr1_i != 5'd0);
        fwd2 = bus.rd_enable_i && (bus.rd_addr_i == bus.raddr2_i) && (bus.raddr2_i != 5'd0);
    end
`else
    // Without forwarding the ports only ever see the stored array contents.
    always_comb begin
        fwd1 = 1'b0;
        fwd2 = 1'b0;
    end
`endif

    // Read data and busy per port; everything is forced quiet while reset is held.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        busy1  = 1'b0;
        busy2  = 1'b0;
        if (rst && bus.re1_i && (bus.raddr1_i != 5'd0)) begin
            rdata1 = fwd1 ? bus.rd_data_i : arr1;
            busy1  = (cnt1 != 2'd0) && !(fwd1 && (cnt1 == 2'd1));
        end
        if (rst && bus.re2_i && (bus.raddr2_i != 5'd0)) begin
            rdata2 = fwd2 ? bus.rd_data_i : arr2;
            busy2  = (cnt2 != 2'd0) && !(fwd2 && (cnt2 == 2'd1));
        end
    end

    assign bus.rdata1_o    = rdata1;
    assign bus.rdata2_o    = rdata2;
    assign bus.stall_req_o = busy1 | busy2;
    assign bus.err_o       = err_q;

    // State registers; reset clears the array, forgets in-flight loads and the error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 1; r < 32; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed bench for register_file. Each step drives the
// inputs on the falling edge, queues the outputs it expects, and compares
// them shortly afterwards, before the next rising edge commits the step.
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic        stall;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t expQ[$];

    register_file_if bus ();

    register_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Wait for the falling edge and drive one cycle of stimulus.
    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic re1, input logic [4:0] a1,
                                 input logic re2, input logic [4:0] a2,
                                 input logic il, input logic [4:0] ird);
        @(negedge clk);
        bus.rd_enable_i  = we;
        bus.rd_addr_i    = wa;
        bus.rd_data_i    = wd;
        bus.re1_i        = re1;
        bus.raddr1_i     = a1;
        bus.re2_i        = re2;
        bus.raddr2_i     = a2;
        bus.issue_load_i = il;
        bus.issue_rd_i   = ird;
    endtask

    // Record what the outputs must show for the stimulus just driven.
    task automatic pushExpected(input string tag, input logic [31:0] r1, input logic [31:0] r2,
                                input logic stall, input logic err);
        exp_t e;
        e.tag    = tag;
        e.rdata1 = r1;
        e.rdata2 = r2;
        e.stall  = stall;
        e.err    = err;
        expQ.push_back(e);
    endtask

    // Let the combinational outputs settle, then compare against the oldest expectation.
    task automatic checkOutput();
        exp_t e;
        #2;
        checks++;
        assert (expQ.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_underflow: observed size=%0d required nonzero", expQ.size());
        end
        if (expQ.size() == 0) return;
        e = expQ.pop_front();
        checks++;
        assert (bus.rdata1_o === e.rdata1) else begin
            errors++;
            $error("[TB] FAIL %s.rdata1: observed=%h expected=%h", e.tag, bus.rdata1_o, e.rdata1);
        end
        checks++;
        assert (bus.rdata2_o === e.rdata2) else begin
            errors++;
            $error("[TB] FAIL %s.rdata2: observed=%h expected=%h", e.tag, bus.rdata2_o, e.rdata2);
        end
        checks++;
        assert (bus.stall_req_o === e.stall) else begin
            errors++;
            $error("[TB] FAIL %s.stall: observed=%b expected=%b", e.tag, bus.stall_req_o, e.stall);
        end
        checks++;
        assert (bus.err_o === e.err) else begin
            errors++;
            $error("[TB] FAIL %s.err: observed=%b expected=%b", e.tag, bus.err_o, e.err);
        end
    endtask

    // Directed sequence covering reset, writes, x0, forwarding, scoreboard and overflow.
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus.rd_enable_i  = 1'b0;
        bus.rd_addr_i    = 5'd0;
        bus.rd_data_i    = 32'h0;
        bus.re1_i        = 1'b0;
        bus.raddr1_i     = 5'd0;
        bus.re2_i        = 1'b0;
        bus.raddr2_i     = 5'd0;
        bus.issue_load_i = 1'b0;
        bus.issue_rd_i   = 5'd0;

        $display("[TB] start, bypass=%0d", BYP);

        applyStimulus(0, 0, 32'h0, 1, 5'd5, 1, 5'd0, 0, 0);
        pushExpected("in_reset", 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput();
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        pushExpected("wr_x5", 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 1, 5'd5, 1, 5'd0, 0, 0);
        pushExpected("rd_x5_x0", 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        checkOutput();

        applyStimulus(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0, 0, 0);
        pushExpected("wr_x0", 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 1, 5'd0, 1, 5'd0, 0, 0);
        pushExpected("rd_x0", 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput();

        applyStimulus(1, 5'd7, 32'h12345678, 1, 5'd5, 1, 5'd7, 0, 0);
        pushExpected("wr_rd_x7", 32'hDEADBEEF, BYP ? 32'h12345678 : 32'h0, 1'b0, 1'b0);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 0, 0, 1, 5'd7, 0, 0);
        pushExpected("rd_x7", 32'h0, 32'h12345678, 1'b0, 1'b0);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 1, 5'd3, 0, 0, 1, 5'd3);
        pushExpected("issue_x3", 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 1, 5'd3, 0, 0, 0, 0);
        pushExpected("busy_x3", 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput();

        applyStimulus(1, 5'd3, 32'hCAFE0003, 1, 5'd3, 0, 0, 0, 0);
        pushExpected("wb_x3", BYP ? 32'hCAFE0003 : 32'h0, 32'h0, !BYP, 1'b0);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 1, 5'd3, 0, 0, 0, 0);
        pushExpected("after_wb_x3", 32'hCAFE0003, 32'h0, 1'b0, 1'b0);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 1, 5'd9);
        pushExpected("issue_x9_a", 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 0, 0, 1, 5'd9, 1, 5'd9);
        pushExpected("issue_x9_b", 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput();

        applyStimulus(1, 5'd9, 32'h00000099, 0, 0, 1, 5'd9, 0, 0);
        pushExpected("wb1_x9", 32'h0, BYP ? 32'h00000099 : 32'h0, 1'b1, 1'b0);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 0, 0, 1, 5'd9, 0, 0);
        pushExpected("still_busy_x9", 32'h0, 32'h00000099, 1'b1, 1'b0);
        checkOutput();

        applyStimulus(1, 5'd9, 32'h0000009A, 0, 0, 1, 5'd9, 0, 0);
        pushExpected("wb2_x9", 32'h0, BYP ? 32'h0000009A : 32'h00000099, !BYP, 1'b0);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 0, 0, 1, 5'd9, 0, 0);
        pushExpected("free_x9", 32'h0, 32'h0000009A, 1'b0, 1'b0);
        checkOutput();

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 1, 5'd11);
            pushExpected($sformatf("fill_x11_%0d", i), 32'h0, 32'h0, 1'b0, 1'b0);
            checkOutput();
        end

        applyStimulus(0, 0, 32'h0, 1, 5'd11, 0, 0, 1, 5'd11);
        pushExpected("overflow_issue", 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 1, 5'd11, 0, 0, 0, 0);
        pushExpected("overflow_err", 32'h0, 32'h0, 1'b1, 1'b1);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
        pushExpected("err_sticky", 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput();

        applyStimulus(1, 5'd11, 32'h00000011, 1, 5'd11, 0, 0, 1, 5'd11);
        pushExpected("issue_wb_same", BYP ? 32'h00000011 : 32'h0, 32'h0, 1'b1, 1'b1);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 1, 5'd11, 0, 0, 0, 0);
        pushExpected("count_held", 32'h00000011, 32'h0, 1'b1, 1'b1);
        checkOutput();

        applyStimulus(1, 5'd12, 32'h00000055, 0, 0, 0, 0, 1, 5'd3);
        pushExpected("issue_x3_wr_x12", 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 1, 5'd3, 1, 5'd12, 0, 0);
        pushExpected("pre_reset", 32'hCAFE0003, 32'h00000055, 1'b1, 1'b1);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 1, 5'd3, 1, 5'd12, 0, 0);
        #1 rst = 1'b0;
        pushExpected("mid_reset", 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput();
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(0, 0, 32'h0, 1, 5'd3, 1, 5'd12, 0, 0);
        pushExpected("post_reset", 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput();

        applyStimulus(0, 0, 32'h0, 1, 5'd11, 1, 5'd9, 0, 0);
        pushExpected("post_reset_x11", 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput();

        checks++;
        assert (expQ.size() == 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_leftover: observed size=%0d required 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

- Writeback endpoint of the pipeline and source of ID-stage operands.
- Consumes the `rd_data`/`rd_addr`/`rd_enable` triple registered out of the MEM/WB stage.
- Holds the 32×32 architectural integer registers and serves two combinational read ports.
- Keeps a per-register load scoreboard that raises a stall request while an ID operand's value is still in flight.

## Interface

Parameters:
- none (width 32, 32 registers, fixed).

Ports:
- `clk`  in  1  — single clock; all state updates on posedge.
- `rst`  in  1  — asynchronous, active-low reset.
- `rd_enable_i`  in  1  — writeback valid, from MEM/WB.
- `rd_addr_i`  in  5  — writeback destination.
- `rd_data_i`  in  32  — writeback value.
- `re1_i`  in  1  — read port 1 enable.
- `raddr1_i`  in  5  — read port 1 address.
- `rdata1_o`  out  32  — read port 1 data, combinational.
- `re2_i`  in  1  — read port 2 enable.
- `raddr2_i`  in  5  — read port 2 address.
- `rdata2_o`  out  32  — read port 2 data, combinational.
- `issue_load_i`  in  1  — ID issues a load this cycle; qualifies `issue_rd_i`.
- `issue_rd_i`  in  5  — destination of the issuing load.
- `stall_req_o`  out  1  — ID must hold; combinational from scoreboard and read ports.
- `err_o`  out  1  — sticky scoreboard overflow flag.

## Operation

- Storage: `regs[1..31]`, 32 bits each; `x0` is not stored.
- Write: at posedge, if `rd_enable_i` and `rd_addr_i != 0`, then `regs[rd_addr_i] <= rd_data_i`. Writes to `x0` are dropped.
- Read, per port p:
  - `re_p == 0` → `rdata_p = 0`.
  - `raddr_p == 0` → `rdata_p = 0`.
  - otherwise → `rdata_p = regs[raddr_p]`, modified by bypass (see Configuration).
- Scoreboard: `cnt[r]`, 2-bit unsigned, r = 1..31. Updated at posedge:
  - `inc = issue_load_i && issue_rd_i == r`.
  - `dec = rd_enable_i && rd_addr_i == r && cnt[r] != 0`.
  - inc only → `+1`; dec only → `-1`; both → unchanged.
  - inc with `cnt[r] == 3` → count stays 3 and `err_o` sets; `err_o` clears only on reset.
  - `x0`: issue and writeback are ignored; `x0` is never busy.
- Stall: `busy_p = re_p && raddr_p != 0 && cnt[raddr_p] != 0`, with a bypass exception (see Configuration). `stall_req_o = busy_1 | busy_2`.
- Squashed instructions must never assert `issue_load_i`; the block has no flush input.
- Reset (`rst == 0`, asynchronous):
  - all `regs` = 0, all `cnt` = 0, `err_o` = 0.
  - `rdata1_o` = `rdata2_o` = 0 and `stall_req_o` = 0 for the whole time reset is held.
  - A load in flight when reset asserts is forgotten.

## Timing

- Write latency: a value presented at edge N is readable from the array in cycle N+1. With bypass, it is also readable in the cycle before edge N.
- Issue at edge N makes `cnt` nonzero from cycle N+1. An issuing instruction never stalls on its own destination.
- Writeback of a load clears its busy bit at that edge. With bypass, the stall already drops in the cycle `rd_enable_i` is presented.
- Simultaneous issue and writeback to the same r: count unchanged. The reader stays stalled if the count is still nonzero.
- Reset deassertion is synchronised externally; the first edge after release performs normal updates.

## Configuration

- Macro: `REGFILE_BYPASS_EN`.

Defined:
- Read data: if `rd_enable_i && rd_addr_i == raddr_p && raddr_p != 0`, then `rdata_p = rd_data_i`.
- Stall exception: `busy_p` is masked when that same forwarding condition holds and `cnt[raddr_p] == 1`.

Undefined:
- Reads return array contents only.
- `busy_p` has no masking. A consumer of a writeback stalls through the write cycle and reads the new value in cycle N+1, one cycle later than with bypass.

## Test plan

- Reset, write `x5 = 0xDEADBEEF`, read port 1 `x5` next cycle → `0xDEADBEEF`; read `x0` → 0.
- Write `x0 = 0xFFFFFFFF`, then read `x0` on both ports → 0, `stall_req_o = 0`.
- Same-cycle write `x7 = 0x12345678` with read port 2 `x7`:
  - with bypass → `0x12345678` that cycle;
  - without bypass → old value, new value next cycle.
- Issue load `x3`, read `x3` next cycle → `stall_req_o = 1` until writeback of `x3`:
  - with bypass, stall drops in the writeback cycle and data = the writeback value;
  - without bypass, stall drops the cycle after.
- Two loads to `x9` issued back-to-back, then one writeback → still stalled; second writeback → stall clears. Issue a fourth outstanding load to a register already at count 3 → `err_o = 1` and it stays 1.
- Assert `rst` low mid-stall with `x3` busy and `x12 = 0x55` → outputs 0 immediately; after release, `x12` reads 0, `x3` is not busy, `err_o = 0`.
